wrap_monitor: RTL and testbench

WRAP_MONITOR -- requirements
Module: wrap_monitor

---
 rtl/wrap_monitor.sv | 157 +++++++++++++++
 tb/tb_wrap_monitor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wrap_monitor.sv
// wrap_monitor: watches an upstream mod-2^N counter for overflow and underflow.
// Keeps a net wrap count, emits a one-cycle strobe per wrap, and drives a
// registered 7-segment display. The display shows the count while running and
// flashes the wrap count (with dp lit) for FLASH_CYCLES cycles after each wrap.
// Optional build macro: WRAP_MONITOR_SAT_EN makes the wrap count saturate at
// its limits instead of wrapping around.
module wrap_monitor #(
  parameter int unsigned NBITS_COUNT  = 4,
  parameter int unsigned NBITS_WRAP   = 4,
  parameter int unsigned FLASH_CYCLES = 4
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic [NBITS_COUNT-1:0] count_in,
  input  logic                   counter_on,
  input  logic                   count_up,
  input  logic                   load,
  output logic [7:0]             seg,
  output logic [NBITS_WRAP-1:0]  wraps,
  output logic                   wrap_pulse,
  output logic                   wrap_dir
);

  localparam int unsigned TimerW = $clog2(FLASH_CYCLES + 1);
  localparam logic [NBITS_COUNT-1:0] CountMax = '1;
  localparam logic [NBITS_WRAP-1:0] WrapMax = '1;
  localparam logic [TimerW-1:0] FlashLoad = TimerW'(FLASH_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StFlash} state_e;

  state_e                  state_q, state_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [NBITS_WRAP-1:0]   wraps_q, wraps_d;
  logic [7:0]              seg_q, seg_d;
  logic                    pulse_q, pulse_d;
  logic                    dir_q, dir_d;
  logic                    overflow, underflow, wrap_event;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Detect wrap events; load masks both because the counter is not stepping.
  always_comb begin
    overflow   = counter_on && !load && count_up && (count_in == CountMax);
    underflow  = counter_on && !load && !count_up && (count_in == '0);
    wrap_event = overflow || underflow;
  end

  // Next wrap count, strobe and direction.
  always_comb begin
    wraps_d = wraps_q;
`ifdef WRAP_MONITOR_SAT_EN
    if (overflow && (wraps_q != WrapMax)) begin
      wraps_d = wraps_q + 1'b1;
    end else if (underflow && (wraps_q != '0)) begin
      wraps_d = wraps_q - 1'b1;
    end
`else
    if (overflow) begin
      wraps_d = wraps_q + 1'b1;
    end else if (underflow) begin
      wraps_d = wraps_q - 1'b1;
    end
`endif
    pulse_d = wrap_event;
    dir_d   = wrap_event ? count_up : dir_q;
  end

  // FSM next state, flash timer and display pattern (seg follows the next state).
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (wrap_event) begin
          state_d = StFlash;
          timer_d = FlashLoad;
        end else if (counter_on || load) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (wrap_event) begin
          state_d = StFlash;
          timer_d = FlashLoad;
        end
      end
      StFlash: begin
        if (wrap_event) begin
          timer_d = FlashLoad;
        end else if (timer_q == TimerW'(1)) begin
          state_d = StRun;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    seg_d = 8'h00;
    unique case (state_d)
      StRun:   seg_d = {1'b0, hex7(4'(count_in))};
      StFlash: seg_d = {1'b1, hex7(4'(wraps_d))};
      default: seg_d = 8'h00;
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      wraps_q <= '0;
      seg_q   <= 8'h00;
      pulse_q <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wraps_q <= wraps_d;
      seg_q   <= seg_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
    end
  end

  assign seg        = seg_q;
  assign wraps      = wraps_q;
  assign wrap_pulse = pulse_q;
  assign wrap_dir   = dir_q;

endmodule

// File: tb/tb_wrap_monitor.sv
// Self-checking bench for wrap_monitor: directed scenarios followed by random
// stimulus, all compared against a cycle-indexed behavioural model.
module tb_wrap_monitor;

  localparam int NC = 4;
  localparam int NW = 4;
  localparam int FC = 4;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] count_in = '0;
  logic          counter_on = 1'b0;
  logic          count_up = 1'b0;
  logic          load = 1'b0;
  logic [7:0]    seg;
  logic [NW-1:0] wraps;
  logic          wrap_pulse;
  logic          wrap_dir;

  int errors = 0;
  int checks = 0;

  // Model: display is blank until first activity; flashing while the edge
  // index is below flash_end; otherwise it shows the sampled count.
  bit         m_started;
  int         m_wraps;
  bit         m_pulse;
  bit         m_dir;
  int         cyc = 0;
  int         flash_end;
  logic [7:0] exp_seg;
  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  wrap_monitor #(
    .NBITS_COUNT (NC),
    .NBITS_WRAP  (NW),
    .FLASH_CYCLES(FC)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .count_in  (count_in),
    .counter_on(counter_on),
    .count_up  (count_up),
    .load      (load),
    .seg       (seg),
    .wraps     (wraps),
    .wrap_pulse(wrap_pulse),
    .wrap_dir  (wrap_dir)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".seg"}, seg, exp_seg);
    chk({tag, ".wraps"}, 8'(wraps), 8'(m_wraps));
    chk({tag, ".pulse"}, 8'(wrap_pulse), 8'(m_pulse));
    chk({tag, ".dir"}, 8'(wrap_dir), 8'(m_dir));
  endtask

  task automatic model_reset();
    m_started = 0;
    m_wraps   = 0;
    m_pulse   = 0;
    m_dir     = 0;
    flash_end = 0;
    exp_seg   = 8'h00;
  endtask

  task automatic model_edge(input bit on, input bit up, input bit ld, input int cin);
    int  lim;
    bit  ovf, unf;
    lim = (1 << NW);
    ovf = on && !ld && up && (cin == (1 << NC) - 1);
    unf = on && !ld && !up && (cin == 0);
`ifdef WRAP_MONITOR_SAT_EN
    if (ovf && m_wraps < lim - 1) m_wraps++;
    if (unf && m_wraps > 0) m_wraps--;
`else
    if (ovf) m_wraps = (m_wraps + 1) % lim;
    if (unf) m_wraps = (m_wraps + lim - 1) % lim;
`endif
    m_pulse = ovf || unf;
    if (m_pulse) begin
      m_dir     = up;
      flash_end = cyc + FC;
      m_started = 1;
    end
    if (on || ld) m_started = 1;
    if (!m_started) exp_seg = 8'h00;
    else if (cyc < flash_end) exp_seg = {1'b1, hex[m_wraps % 16]};
    else exp_seg = {1'b0, hex[cin % 16]};
    cyc++;
  endtask

  // Drive inputs just after an edge, clock once, then compare.
  task automatic step(input string tag, input bit on, input bit up, input bit ld,
                      input int cin);
    counter_on = on;
    count_up   = up;
    load       = ld;
    count_in   = NC'(cin);
    @(posedge clk_2);
    model_edge(on, up, ld, cin);
    #1;
    check_all(tag);
  endtask

  // Reset pulse between clock edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 check_all("reset_async");
    @(posedge clk_2);
    @(posedge clk_2);
    #1 check_all("reset_held");
    @(negedge clk_2);
    reset = 1'b0;
    @(posedge clk_2);
    #1;

    step("idle_quiet", 0, 1, 0, 5);

    // Count up 0..F then 0..5: one overflow, flash, then back to the count.
    for (int i = 0; i < 16; i++) step("up_count", 1, 1, 0, i);
    for (int i = 0; i < 6; i++) step("after_ovf", 1, 1, 0, i);

    // Two underflows: 1 -> 0 -> F (or held at 0 when saturating).
    step("underflow1", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("uf1_flash", 1, 0, 0, 9);
    step("underflow2", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("uf2_flash", 1, 0, 0, 9);

    // Load masks an overflow; IDLE moves to RUN and shows F.
    mid_reset("reset_before_load");
    step("load_masks", 1, 1, 1, 15);
    step("load_hold", 0, 1, 0, 15);

    // Back-to-back overflows extend the flash.
    step("ovf_a", 1, 1, 0, 15);
    step("ovf_b", 1, 1, 0, 15);
    for (int i = 0; i < 6; i++) step("extended", 1, 1, 0, 3);

    // Reset aborts a flash mid-way; nothing left over after release.
    step("ovf_c", 1, 1, 0, 15);
    step("flash_2nd", 1, 1, 0, 4);
    mid_reset("reset_mid_flash");
    step("post_reset_idle", 0, 1, 0, 7);
    step("post_reset_idle2", 0, 0, 0, 0);

    // Random traffic biased toward the wrap boundaries.
    for (int i = 0; i < 400; i++) begin
      int r, cin;
      r   = $urandom_range(0, 3);
      cin = (r == 0) ? 0 : (r == 1) ? 15 : int'($urandom_range(0, 15));
      step("random", $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0, cin);
      if ($urandom_range(0, 49) == 0) mid_reset("random_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
